// File: rtl/alu_defs_pkg.sv
// Shared opcode/func constants, issue FSM encoding and flag bit positions
// for the ALU issue controller and its decoder.
package alu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // zon flag vector layout: {zero, overflow, negative}
    localparam int ZON_Z = 2;
    localparam int ZON_O = 1;
    localparam int ZON_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction classifier: which words the ALU supports,
// which write HI/LO and which read them back.
module alu_issue_decode
    import alu_defs_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_supported,
    output logic        is_hilo_wr,
    output logic        is_mfhi,
    output logic        is_mflo
);

    logic [5:0] opcode;
    logic [5:0] func;

    // register/shamt fields only matter to the ALU itself
    logic unused_fields;
    assign unused_fields = ^instr[25:6];

    assign opcode = instr[31:26];
    assign func   = instr[5:0];

    always_comb begin
        is_supported = 1'b0;
        is_hilo_wr   = 1'b0;
        is_mfhi      = 1'b0;
        is_mflo      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_SLL, FN_SRL, FN_SRA,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: begin
                        is_supported = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        is_supported = 1'b1;
                        is_hilo_wr   = 1'b1;
                    end
                    FN_MFHI: begin
                        is_supported = 1'b1;
                        is_mfhi      = 1'b1;
                    end
                    FN_MFLO: begin
                        is_supported = 1'b1;
                        is_mflo      = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
                is_supported = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller around an external combinational ALU: latches an
// instruction, waits one settle cycle, holds the result until consumed.
module alu_issue_ctrl
    import alu_defs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_gr1,
    input  logic [DATA_W-1:0] in_gr2,
    output logic [31:0]       alu_i_datain,
    output logic [DATA_W-1:0] alu_gr1,
    output logic [DATA_W-1:0] alu_gr2,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic [DATA_W-1:0] alu_lo,
    input  logic [2:0]        alu_zon,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_zon,
    output logic              out_err,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic [CNT_W-1:0]  cnt_issued,
    output logic [CNT_W-1:0]  cnt_err
);

    state_t            state_reg, state_next;
    logic [31:0]       instr_reg;
    logic [DATA_W-1:0] gr1_reg, gr2_reg;
    logic [DATA_W-1:0] result_reg, hi_reg, lo_reg;
    logic [2:0]        zon_reg;
    logic              err_reg;

    logic [31:0]       dec_instr;
    logic              dec_supported, dec_hilo_wr, dec_mfhi, dec_mflo;
    logic              wb_done;
    logic [1:0]        cnt_inc;

    // In IDLE classify the offered word, afterwards the latched one
    assign dec_instr = (state_reg == ST_IDLE) ? in_instr : instr_reg;

    alu_issue_decode u_decode (
        .instr        (dec_instr),
        .is_supported (dec_supported),
        .is_hilo_wr   (dec_hilo_wr),
        .is_mfhi      (dec_mfhi),
        .is_mflo      (dec_mflo)
    );

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_WB);
    assign wb_done   = (state_reg == ST_WB) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = (dec_mfhi || dec_mflo) ? ST_WB : ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg  <= '0;
            gr1_reg    <= '0;
            gr2_reg    <= '0;
            result_reg <= '0;
            zon_reg    <= '0;
            err_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_reg <= in_instr;
                        gr1_reg   <= in_gr1;
                        gr2_reg   <= in_gr2;
                        // HI/LO reads complete here, skipping the ALU
                        if (dec_mfhi || dec_mflo) begin
                            result_reg <= dec_mfhi ? hi_reg : lo_reg;
                            zon_reg    <= '0;
                            err_reg    <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    err_reg <= !dec_supported;
                    if (dec_supported && !dec_hilo_wr) begin
                        result_reg <= alu_c;
                        zon_reg    <= alu_zon;
                    end else begin
                        result_reg <= '0;
                        zon_reg    <= '0;
                    end
                    if (dec_supported && dec_hilo_wr) begin
                        hi_reg <= alu_hi;
                        lo_reg <= alu_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_inc[0] = wb_done;
    assign cnt_inc[1] = wb_done && err_reg;

    // Saturating status counters: [0] completed, [1] erroneous
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt_issued   = g_cnt[0].cnt_reg;
    assign cnt_err      = g_cnt[1].cnt_reg;
    assign alu_i_datain = instr_reg;
    assign alu_gr1      = gr1_reg;
    assign alu_gr2      = gr2_reg;
    assign out_result   = result_reg;
    assign out_zon      = zon_reg;
    assign out_err      = err_reg;
    assign hi_q         = hi_reg;
    assign lo_q         = lo_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, table of vectors with a result
// scoreboard, plus stall, saturation and mid-operation reset sequences.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_gr1, in_gr2;
    logic [31:0]       alu_i_datain;
    logic [DATA_W-1:0] alu_gr1, alu_gr2;
    logic [DATA_W-1:0] alu_c, alu_hi, alu_lo;
    logic [2:0]        alu_zon;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [2:0]        out_zon;
    logic              out_err;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_issued, cnt_err;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_gr1       (in_gr1),
        .in_gr2       (in_gr2),
        .alu_i_datain (alu_i_datain),
        .alu_gr1      (alu_gr1),
        .alu_gr2      (alu_gr2),
        .alu_c        (alu_c),
        .alu_hi       (alu_hi),
        .alu_lo       (alu_lo),
        .alu_zon      (alu_zon),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zon      (out_zon),
        .out_err      (out_err),
        .hi_q         (hi_q),
        .lo_q         (lo_q),
        .cnt_issued   (cnt_issued),
        .cnt_err      (cnt_err)
    );

    // Behavioural external ALU (shifts act on gr1 by shamt)
    always_comb begin
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] a, b, imm_se, imm_ze;
        logic [63:0] prod;
        logic        ovf;
        op = alu_i_datain[31:26];
        fn = alu_i_datain[5:0];
        sh = alu_i_datain[10:6];
        a  = alu_gr1;
        b  = alu_gr2;
        imm_se = {{16{alu_i_datain[15]}}, alu_i_datain[15:0]};
        imm_ze = {16'h0, alu_i_datain[15:0]};
        alu_c  = '0;
        alu_hi = '0;
        alu_lo = '0;
        ovf    = 1'b0;
        prod   = '0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: alu_c = a << sh;
                6'h02: alu_c = a >> sh;
                6'h03: alu_c = $signed(a) >>> sh;
                6'h20: begin alu_c = a + b; ovf = (a[31] == b[31]) && (alu_c[31] != a[31]); end
                6'h21: alu_c = a + b;
                6'h22: begin alu_c = a - b; ovf = (a[31] != b[31]) && (alu_c[31] != a[31]); end
                6'h23: alu_c = a - b;
                6'h24: alu_c = a & b;
                6'h25: alu_c = a | b;
                6'h26: alu_c = a ^ b;
                6'h27: alu_c = ~(a | b);
                6'h2A: alu_c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: alu_c = (a < b) ? 32'd1 : 32'd0;
                6'h18: begin prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); alu_hi = prod[63:32]; alu_lo = prod[31:0]; end
                6'h19: begin prod = {32'h0, a} * {32'h0, b}; alu_hi = prod[63:32]; alu_lo = prod[31:0]; end
                6'h1A: if (b != 0) begin alu_lo = $signed(a) / $signed(b); alu_hi = $signed(a) % $signed(b); end
                6'h1B: if (b != 0) begin alu_lo = a / b; alu_hi = a % b; end
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: begin alu_c = a + imm_se; ovf = (a[31] == imm_se[31]) && (alu_c[31] != a[31]); end
                6'h09: alu_c = a + imm_se;
                6'h0C: alu_c = a & imm_ze;
                6'h0D: alu_c = a | imm_ze;
                default: ;
            endcase
        end
        alu_zon = {(alu_c == 0), ovf, alu_c[31]};
    end

    typedef struct {
        logic [31:0] res;
        logic [2:0]  zon;
        logic        err;
    } sb_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  zon;
        logic        err;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[14];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;
    logic [CNT_W-1:0] exp_issued = '0;
    logic [CNT_W-1:0] exp_err    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: compares at every result handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                n_txn++;
                $display("txn %0d: result=%h zon=%b err=%b (exp %h %b %b)",
                         n_txn, out_result, out_zon, out_err, e.res, e.zon, e.err);
                check("out_result", out_result, e.res);
                check("out_zon", out_zon, e.zon);
                check("out_err", out_err, e.err);
                if (exp_issued != CNT_MAX) exp_issued = exp_issued + 1'b1;
                if (e.err && exp_err != CNT_MAX) exp_err = exp_err + 1'b1;
            end
        end
    end

    // Offer one instruction, wait for acceptance and check latency to out_valid
    task automatic do_issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic [2:0] zon, input logic err,
                            input int lat_exp);
        int w;
        int lat;
        sb_q.push_back('{res, zon, err});
        in_instr = instr;
        in_gr1   = a;
        in_gr2   = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, lat_exp);
    endtask

    task automatic wait_drop();
        int d;
        d = 0;
        while (out_valid && d < 20) begin
            @(posedge clk); #1;
            d++;
        end
        if (out_valid) check("handshake_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00000020, 32'hC0404040, 32'hFFFFFFFF, 32'hC040403F, 3'b001, 1'b0, 2, 32'h0, 32'h0};
        vecs[1]  = '{32'h200000D0, 32'h00000001, 32'h00000000, 32'h000000D1, 3'b000, 1'b0, 2, 32'h0, 32'h0};
        vecs[2]  = '{32'h00011040, 32'hDDDDDDDD, 32'h00000000, 32'hBBBBBBBA, 3'b001, 1'b0, 2, 32'h0, 32'h0};
        vecs[3]  = '{32'h00000022, 32'h00000005, 32'h00000005, 32'h00000000, 3'b100, 1'b0, 2, 32'h0, 32'h0};
        vecs[4]  = '{32'h00000020, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b011, 1'b0, 2, 32'h0, 32'h0};
        vecs[5]  = '{32'h0000002B, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 2, 32'h0, 32'h0};
        vecs[6]  = '{32'h00000018, 32'h00000006, 32'h00000007, 32'h00000000, 3'b000, 1'b0, 2, 32'h0, 32'd42};
        vecs[7]  = '{32'h00000010, 32'h00000000, 32'h00000000, 32'h00000000, 3'b000, 1'b0, 1, 32'h0, 32'd42};
        vecs[8]  = '{32'h00000012, 32'h00000000, 32'h00000000, 32'd42,       3'b000, 1'b0, 1, 32'h0, 32'd42};
        vecs[9]  = '{32'h3400F0F0, 32'h12340000, 32'h00000000, 32'h1234F0F0, 3'b000, 1'b0, 2, 32'h0, 32'd42};
        vecs[10] = '{32'h00000019, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 3'b000, 1'b0, 2, 32'h1, 32'hFFFFFFFE};
        vecs[11] = '{32'h00000010, 32'h00000000, 32'h00000000, 32'h00000001, 3'b000, 1'b0, 1, 32'h1, 32'hFFFFFFFE};
        vecs[12] = '{32'h0000001B, 32'd100,      32'd7,        32'h00000000, 3'b000, 1'b0, 2, 32'h2, 32'd14};
        vecs[13] = '{32'h00000012, 32'h00000000, 32'h00000000, 32'd14,       3'b000, 1'b0, 1, 32'h2, 32'd14};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000020;
        in_gr1    = 32'hA5A5A5A5;
        in_gr2    = 32'h5A5A5A5A;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_zon", out_zon, 0);
        check("rst_hi_lo", {hi_q, lo_q}, 0);
        check("rst_counters", {cnt_issued, cnt_err}, 0);
        check("rst_alu_datain", alu_i_datain, 0);
        check("rst_alu_gr", {alu_gr1, alu_gr2}, 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) begin
            do_issue(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zon, vecs[i].err, vecs[i].lat);
            wait_drop();
            check("hi_q", hi_q, vecs[i].hi);
            check("lo_q", lo_q, vecs[i].lo);
            check("cnt_issued", cnt_issued, exp_issued);
        end

        // Consumer stall: result must hold steady while out_ready is low
        out_ready = 1'b0;
        do_issue(32'h00000021, 32'h11111111, 32'h22222222, 32'h33333333, 3'b000, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_out_result", out_result, 32'h33333333);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_drop();

        do_issue(32'hFC000000, 32'h00000001, 32'h00000002, 32'h00000000, 3'b000, 1'b1, 2);
        wait_drop();
        check("cnt_err_after_err", cnt_err, 1);
        check("err_keeps_hi_lo", {hi_q, lo_q}, {32'h2, 32'd14});

        // Counters are at their ceiling; another completion must not wrap
        check("cnt_issued_at_max", cnt_issued, CNT_MAX);
        do_issue(32'h00000024, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000, 1'b0, 2);
        wait_drop();
        check("cnt_issued_saturated", cnt_issued, CNT_MAX);
        check("cnt_issued_model", cnt_issued, exp_issued);
        check("cnt_err_model", cnt_err, exp_err);

        // Fresh reset, then reset again while a mult is in EXEC
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        sb_q.delete();
        exp_issued = '0;
        exp_err    = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        in_instr = 32'h00000018;
        in_gr1   = 32'd3;
        in_gr2   = 32'd5;
        in_valid = 1'b1;
        check("pre_mult_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_hi_lo", {hi_q, lo_q}, 0);
        check("midrst_cnt_issued", cnt_issued, 0);
        check("after_rst_idle", in_ready, 1);
        check("after_rst_no_output", out_valid, 0);

        do_issue(32'h00000012, 32'h0, 32'h0, 32'h00000000, 3'b000, 1'b0, 1);
        wait_drop();
        check("post_rst_cnt_issued", cnt_issued, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
